// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave with fixed response latency.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        cap_write;
   logic [2:0]  cap_funct3;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic [1:0]    hlane;
   logic [31:0]   word;
   logic [31:0]   word_b;
   logic [31:0]   word_h;
   logic          fault;
   logic [3:0]    be;
   logic [31:0]   wd;
   logic [31:0]   ld;
   logic          commit;

   assign req_ready = (state == IDLE) && !reset;

   // Decode works on the captured request, so the array read happens at the response edge.
   always_comb begin
      off    = cap_addr - ADDR_BASE;
      idx    = off[AW+1:2];
      lane   = off[1:0];
      hlane  = {lane[1], 1'b0};
      word   = mem[idx];
      word_b = word >> {lane, 3'b000};
      word_h = word >> {hlane, 3'b000};
      fault  = ({1'b0, off} >= LIMIT);
      be     = '0;
      wd     = '0;
      ld     = '0;
      if (cap_write) begin
         case (cap_funct3)
            3'd0: begin
               be = 4'b0001 << lane;
               wd = {4{cap_wdata[7:0]}};
            end
            3'd1: begin
               be = 4'b0011 << hlane;
               wd = {2{cap_wdata[15:0]}};
            end
            3'd2: begin
               be = 4'b1111;
               wd = cap_wdata;
            end
            default: fault = 1'b1;
         endcase
      end else begin
         case (cap_funct3)
            3'd0:    ld = {{24{word_b[7]}}, word_b[7:0]};
            3'd4:    ld = {24'd0, word_b[7:0]};
            3'd1:    ld = {{16{word_h[15]}}, word_h[15:0]};
            3'd5:    ld = {16'd0, word_h[15:0]};
            3'd2:    ld = word;
            default: fault = 1'b1;
         endcase
      end
`ifdef DMEM_MISALIGN_TRAP_EN
      if ((cap_funct3[1:0] == 2'd1 && lane[0]) || (cap_funct3[1:0] == 2'd2 && lane != 2'd0))
         fault = 1'b1;
`endif
      commit = (state == WAIT) && (cnt == 4'd0) && cap_write && !fault && !reset;
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i])
               mem[idx][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         cap_write  <= 1'b0;
         cap_funct3 <= '0;
         cap_addr   <= '0;
         cap_wdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cap_write  <= req_write;
                  cap_funct3 <= req_funct3;
                  cap_addr   <= req_addr;
                  cap_wdata  <= req_wdata;
                  cnt        <= CNT_INIT;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= fault;
                  rsp_rdata <= (fault || cap_write) ? '0 : ld;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed plan plus random traffic against a byte-addressed reference memory.
// Honours DMEM_MISALIGN_TRAP_EN the same way the design does.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned LAT   = 2;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks = 0;
   int errors = 0;

   logic [7:0] bmem [DEPTH*4];

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .ADDR_BASE(BASE)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: byte-addressed memory, access size 1/2/4 from funct3[1:0].
   task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic er);
      logic [31:0] off;
      int unsigned size;
      bit ok;
      off = addr - BASE;
      rd  = '0;
      er  = 1'b0;
      if (off >= DEPTH*4) er = 1'b1;
      if (w) ok = (f3 <= 3'd2);
      else   ok = (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
      if (!ok) er = 1'b1;
      if (er) return;
      size = 1 << f3[1:0];
      if (off % size != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
         er = 1'b1;
         return;
`else
         off = off - (off % size);
`endif
      end
      if (w) begin
         for (int unsigned k = 0; k < size; k++) bmem[off+k] = wdata[8*k +: 8];
      end else begin
         for (int unsigned k = 0; k < size; k++) rd[8*k +: 8] = bmem[off+k];
         if (!f3[2] && size == 1) rd = {{24{rd[7]}}, rd[7:0]};
         if (!f3[2] && size == 2) rd = {{16{rd[15]}}, rd[15:0]};
      end
   endtask

   // One full transaction; bp = cycles rsp_ready is withheld after rsp_valid rises.
   task automatic xact(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int bp,
                       output logic [31:0] rd, output logic er);
      logic [31:0] erd;
      logic        eer;
      int          lat;
      model(w, f3, addr, wdata, erd, eer);
      chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk); #1;
      // A competing store held on the request side while busy must be ignored.
      req_write  = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = $urandom_range(0, 15) * 4;
      req_wdata  = $urandom;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         chk("req_ready_wait", {31'b0, req_ready}, 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), LAT);
      chk("rdata", rsp_rdata, erd);
      chk("err", {31'b0, rsp_err}, {31'b0, eer});
      rd = rsp_rdata;
      er = rsp_err;
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("bp_rdata", rsp_rdata, erd);
         chk("bp_err", {31'b0, rsp_err}, {31'b0, eer});
         chk("bp_ready", {31'b0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      chk("drop_valid", {31'b0, rsp_valid}, 32'd0);
      chk("ready_after", {31'b0, req_ready}, 32'd1);
   endtask

   initial begin : main
      logic [31:0] rd;
      logic        er;
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

      @(posedge clk); #1;
      chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

      for (int i = 0; i < 16; i++) xact(1'b1, 3'd2, 32'(i * 4), $urandom, 0, rd, er);

      xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
      xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
      chk("lw_deadbeef", rd, 32'hDEADBEEF);
      xact(1'b1, 3'd0, 32'h13, 32'h80, 0, rd, er);
      xact(1'b0, 3'd0, 32'h13, 32'h0, 0, rd, er);
      chk("lb_sext", rd, 32'hFFFFFF80);
      xact(1'b0, 3'd4, 32'h13, 32'h0, 0, rd, er);
      chk("lbu_zext", rd, 32'h00000080);
      xact(1'b0, 3'd2, 32'h10, 32'h0, 5, rd, er);
      chk("lw_merged", rd, 32'h80ADBEEF);

      xact(1'b0, 3'd2, 32'h12, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("mis_lw_err", {31'b0, er}, 32'd1);
      chk("mis_lw_rdata", rd, 32'h0);
`else
      chk("mis_lw_err", {31'b0, er}, 32'd0);
      chk("mis_lw_rdata", rd, 32'h80ADBEEF);
`endif

      xact(1'b0, 3'd2, 32'h0, 32'h0, 0, rd, er);
      xact(1'b1, 3'd2, 32'(DEPTH * 4), 32'h5555AAAA, 0, rd, er);
      chk("oor_err", {31'b0, er}, 32'd1);
      xact(1'b0, 3'd2, 32'h0, 32'h0, 0, rd, er);
      xact(1'b0, 3'd3, 32'h10, 32'h0, 0, rd, er);
      chk("f3_err", {31'b0, er}, 32'd1);
      chk("f3_rdata", rd, 32'h0);
      xact(1'b1, 3'd5, 32'h10, 32'hFFFFFFFF, 0, rd, er);
      xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);

      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
      req_addr = 32'h20; req_wdata = 32'h12345678;
      chk("abort_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_valid0", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      chk("abort_valid1", {31'b0, rsp_valid}, 32'd0);
      reset = 1'b0;
      #1;
      chk("abort_ready_post", {31'b0, req_ready}, 32'd1);
      xact(1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er);

      for (int i = 0; i < 80; i++) begin
         w  = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 9))
            0:       a = 32'(DEPTH * 4) + 32'($urandom_range(0, 15));
            1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: a = 32'($urandom_range(0, 63));
         endcase
         xact(w, f3, a, $urandom, $urandom_range(0, 3), rd, er);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
